dtw_ref_rd_arbiter: RTL and testbench

Shares the single read port of the DTW reference memory between NUM_CORES DTW cores in the multi-accelerator build. Each core posts a reference address; the arbiter grants one core per cycle in round-robin order and drives the memory address. It returns the read data to the winning core with a one-hot valid, tracking in-flight reads through a tag pipeline matched to the memory read latency. It sits between the cores and the reference-memory wrapper, and is enabled only once the reference load has completed.

---
 rtl/dtw_ref_rd_arbiter.sv | 149 ++++++++++++++
 tb/tb_dtw_ref_rd_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_ref_rd_arbiter.sv
// Round-robin arbiter sharing the DTW reference-memory read port among NUM_CORES cores.
// Read data returns to the winner with a one-hot valid, tracked by a latency-matched tag pipe.
module dtw_ref_rd_arbiter #(
    parameter int NUM_CORES        = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter int RD_LATENCY       = 1
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  en_in,
    input  logic [NUM_CORES-1:0]                  req_in,
    input  logic [NUM_CORES*REFMEM_PTR_WIDTH-1:0] addr_in,
    output logic [NUM_CORES-1:0]                  gnt_out,
    output logic [NUM_CORES-1:0]                  rd_valid_out,
    output logic [DATA_WIDTH-1:0]                 rd_data_out,
    output logic                                  mem_rden_out,
    output logic [REFMEM_PTR_WIDTH-1:0]           mem_addr_out,
    input  logic [DATA_WIDTH-1:0]                 mem_data_in,
    output logic                                  busy_out,
    output logic [1:0]                            dbg_state
);
    localparam int              ID_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [ID_W:0]   NC      = (ID_W+1)'(NUM_CORES);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, DRAIN = 2'd2} state_t;

    state_t                      state_q, state_d;
    logic [ID_W-1:0]             rr_q, rr_d;
    logic [RD_LATENCY-1:0]       tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]             tag_id_q [RD_LATENCY];
    logic [ID_W-1:0]             tag_id_d [RD_LATENCY];
    logic [NUM_CORES-1:0]        rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                        mem_rden_q, mem_rden_d;
    logic [REFMEM_PTR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                        busy_q, busy_d;

    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W:0]   scan_idx;
    logic            grant;
    logic            in_flight;

    // Scan from the rr pointer upward, wrapping, and take the first requester.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = {1'b0, rr_q} + (ID_W+1)'(k);
            if (scan_idx >= NC) begin
                scan_idx = scan_idx - NC;
            end
            if (!win_found && req_in[scan_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    assign grant     = (state_q == ARB) && en_in && win_found;
    assign in_flight = |tag_vld_q;

    always_comb begin
        gnt_out    = '0;
        rr_d       = rr_q;
        mem_rden_d = grant;
        mem_addr_d = mem_addr_q;
        if (grant) begin
            gnt_out[win_id] = 1'b1;
            rr_d            = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant && (win_id == ID_W'(i))) begin
                mem_addr_d = addr_in[i*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH];
            end
        end

        tag_vld_d[0] = grant;
        tag_id_d[0]  = win_id;
        for (int s = 1; s < RD_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        // The tag leaving the last stage lines up with its memory data this cycle.
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        if (tag_vld_q[RD_LATENCY-1]) begin
            rd_valid_d[tag_id_q[RD_LATENCY-1]] = 1'b1;
            rd_data_d                          = mem_data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_in) state_d = ARB;
            ARB:     if (!en_in) state_d = in_flight ? DRAIN : IDLE;
            DRAIN: begin
                if (en_in) begin
                    state_d = ARB;
                end else if (!in_flight) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (|tag_vld_d);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            tag_vld_q  <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            mem_rden_q <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            tag_vld_q  <= tag_vld_d;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            mem_rden_q <= mem_rden_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_valid_out = rd_valid_q;
    assign rd_data_out  = rd_data_q;
    assign mem_rden_out = mem_rden_q;
    assign mem_addr_out = mem_addr_q;
    assign busy_out     = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dtw_ref_rd_arbiter.sv
// Scoreboard bench for dtw_ref_rd_arbiter: two instances (read latency 1 and 3) share
// stimulus; expected reads are queued at grant time and popped by a monitor on valid.
module tb_dtw_ref_rd_arbiter;
    logic        clk_in;
    logic        rst_in;
    logic        en_in;
    logic [3:0]  req_in;
    logic [19:0] addr [4];
    logic [79:0] addr_in;

    logic [3:0]  gnt1, v1, gnt3, v3;
    logic [15:0] d1, d3, mdat1, mdat3;
    logic        rden1, rden3, busy1, busy3;
    logic [19:0] maddr1, maddr3, h3a, h3b;
    logic [1:0]  st1, st3;

    typedef struct {
        logic [3:0]  oh;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rden_cnt = 0;
    bit started = 0;

    assign addr_in = {addr[3], addr[2], addr[1], addr[0]};

    dtw_ref_rd_arbiter #(.NUM_CORES(4), .DATA_WIDTH(16), .REFMEM_PTR_WIDTH(20), .RD_LATENCY(1)) u_dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .req_in(req_in), .addr_in(addr_in),
        .gnt_out(gnt1), .rd_valid_out(v1), .rd_data_out(d1), .mem_rden_out(rden1),
        .mem_addr_out(maddr1), .mem_data_in(mdat1), .busy_out(busy1), .dbg_state(st1));

    dtw_ref_rd_arbiter #(.NUM_CORES(4), .DATA_WIDTH(16), .REFMEM_PTR_WIDTH(20), .RD_LATENCY(3)) u_dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .req_in(req_in), .addr_in(addr_in),
        .gnt_out(gnt3), .rd_valid_out(v3), .rd_data_out(d3), .mem_rden_out(rden3),
        .mem_addr_out(maddr3), .mem_data_in(mdat3), .busy_out(busy3), .dbg_state(st3));

    function automatic logic [15:0] memf(input logic [19:0] a);
        return a[15:0] * 16'd7 + 16'h1000;
    endfunction

    // Reference memory contents; the latency-3 memory sees its address two cycles late.
    assign mdat1 = memf(maddr1);
    assign mdat3 = memf(h3b);
    always @(posedge clk_in) begin
        h3a <= maddr3;
        h3b <= h3a;
    end

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected no event (cycle %0d)", nm, act, cyc);
    endtask

    always @(negedge clk_in) begin
        if (started && !rst_in) begin
            if (rden1) rden_cnt++;
            if (q1.size() > 0 && q1[0].due < cyc) begin
                flag("L1_missing_valid", 32'(q1[0].due));
                void'(q1.pop_front());
            end
            if (v1 != 4'b0) begin
                if (q1.size() == 0) flag("L1_unexpected_valid", 32'(v1));
                else begin
                    e1 = q1.pop_front();
                    chk("L1_valid", 32'(v1), 32'(e1.oh));
                    chk("L1_data", 32'(d1), 32'(e1.data));
                    chk("L1_cycle", cyc, e1.due);
                end
            end
            if (q3.size() > 0 && q3[0].due < cyc) begin
                flag("L3_missing_valid", 32'(q3[0].due));
                void'(q3.pop_front());
            end
            if (v3 != 4'b0) begin
                if (q3.size() == 0) flag("L3_unexpected_valid", 32'(v3));
                else begin
                    e3 = q3.pop_front();
                    chk("L3_valid", 32'(v3), 32'(e3.oh));
                    chk("L3_data", 32'(d3), 32'(e3.data));
                    chk("L3_cycle", cyc, e3.due);
                end
            end
        end
    end

    // Called just after a rising edge; applies one cycle of stimulus and advances.
    task automatic drive(input logic en, input logic [3:0] req, input logic [3:0] eg);
        exp_t x;
        en_in  = en;
        req_in = req;
        #1;
        chk("gnt_L1", 32'(gnt1), 32'(eg));
        chk("gnt_L3", 32'(gnt3), 32'(eg));
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                x.oh   = eg;
                x.data = memf(addr[i]);
                x.due  = cyc + 2;
                q1.push_back(x);
                x.due  = cyc + 4;
                q3.push_back(x);
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_in  = 1'b1;
        started = 1;
        en_in   = 1'b0;
        req_in  = 4'b0;
        #1;
        chk("rst_gnt", 32'(gnt1), 0);
        chk("rst_valid_L1", 32'(v1), 0);
        chk("rst_valid_L3", 32'(v3), 0);
        chk("rst_data", 32'(d1), 0);
        chk("rst_rden", 32'(rden1), 0);
        chk("rst_addr", 32'(maddr1), 0);
        chk("rst_busy_L1", 32'(busy1), 0);
        chk("rst_busy_L3", 32'(busy3), 0);
        chk("rst_state_L3", 32'(st3), 0);
        q1.delete();
        q3.delete();
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0;
        en_in  = 1'b0;
        req_in = 4'b0;
        addr[0] = 20'h00001;
        addr[1] = 20'h00002;
        addr[2] = 20'h00010;
        addr[3] = 20'h00004;
        @(posedge clk_in);
        #1;
        do_reset();

        // Single core: core 2 at 0x00010.
        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0100, 4'b0100);
        chk("single_addr", 32'(maddr1), 32'h10);
        chk("single_rden", 32'(rden1), 1);
        chk("single_addr_L3", 32'(maddr3), 32'h10);
        drive(1'b1, 4'b0000, 4'b0000);
        chk("idle_rden", 32'(rden1), 0);
        chk("hold_addr", 32'(maddr1), 32'h10);

        // Pointer wrap: pointer at 3, cores 1 and 3 request.
        drive(1'b1, 4'b1010, 4'b1000);
        drive(1'b1, 4'b0010, 4'b0010);
        drive(1'b1, 4'b0110, 4'b0100);
        drive(1'b1, 4'b0010, 4'b0010);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'b0000, 4'b0000);

        // All-request fairness from reset.
        addr[0] = 20'h1; addr[1] = 20'h2; addr[2] = 20'h3; addr[3] = 20'h4;
        do_reset();
        drive(1'b1, 4'b1111, 4'b0000);
        for (int k = 0; k < 8; k++) drive(1'b1, 4'b1111, 4'(1 << (k % 4)));

        // Asynchronous reset with reads in flight.
        do_reset();
        drive(1'b1, 4'b0011, 4'b0000);
        rden_cnt = 0;
        drive(1'b1, 4'b0011, 4'b0001);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000, 4'b0000);
        chk("withdraw_rden_cnt", rden_cnt, 1);

        // Disable with one read in flight.
        drive(1'b1, 4'b0100, 4'b0100);
        drive(1'b0, 4'b1111, 4'b0000);
        chk("drain_state_L3", 32'(st3), 2);
        chk("drain_state_L1", 32'(st1), 2);
        chk("drain_busy_L3", 32'(busy3), 1);
        drive(1'b0, 4'b1111, 4'b0000);
        chk("idle_state_L1", 32'(st1), 0);
        chk("idle_busy_L1", 32'(busy1), 0);
        chk("drain2_state_L3", 32'(st3), 2);
        drive(1'b0, 4'b1111, 4'b0000);
        chk("drain3_state_L3", 32'(st3), 2);
        drive(1'b0, 4'b0000, 4'b0000);
        chk("end_state_L3", 32'(st3), 0);
        chk("end_busy_L3", 32'(busy3), 0);

        for (int i = 0; i < 4; i++) drive(1'b0, 4'b0000, 4'b0000);
        chk("q1_empty", 32'(q1.size()), 0);
        chk("q3_empty", 32'(q3.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
